// File: rtl/bus_host_arbiter_2.sv
// Two-host round-robin arbiter sharing one downstream memory-mapped bus.
// One outstanding transaction at a time, with a per-transaction watchdog
// that terminates hung accesses with an error response.
module bus_host_arbiter_2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] h0_address,
  input  logic [31:0] h0_data_write,
  input  logic [3:0]  h0_write_mask,
  input  logic        h0_ren,
  input  logic        h0_wen,
  output logic [31:0] h0_data_read,
  output logic        h0_ready,
  input  logic [31:0] h1_address,
  input  logic [31:0] h1_data_write,
  input  logic [3:0]  h1_write_mask,
  input  logic        h1_ren,
  input  logic        h1_wen,
  output logic [31:0] h1_data_read,
  output logic        h1_ready,
  output logic [31:0] dev_address,
  output logic [31:0] dev_data_write,
  output logic [3:0]  dev_write_mask,
  output logic        dev_ren,
  output logic        dev_wen,
  input  logic [31:0] dev_data_read,
  input  logic        dev_ready,
  output logic [1:0]  grant,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE,
    G0,
    G1
  } state_t;

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic req0, req1, own_req, timeout;

  assign req0 = h0_ren | h0_wen;
  assign req1 = h1_ren | h1_wen;

  // Request of whichever host currently owns the bus.
  always_comb begin
    own_req = 1'b0;
    case (state_q)
      G0:      own_req = req0;
      G1:      own_req = req1;
      default: own_req = 1'b0;
    endcase
  end

  // Watchdog fires only while the owner is still waiting; dev_ready wins a tie.
  assign timeout = (state_q != IDLE) & own_req & ~dev_ready & (cnt_q == CNT_LIMIT);

  // State, last-grant and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitration in IDLE, completion/abandon/timeout in a grant state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = last_q ? G0 : G1;
          last_d  = ~last_q;
        end else if (req0) begin
          state_d = G0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = G1;
          last_d  = 1'b1;
        end
      end
      G0, G1: begin
        if (dev_ready || !own_req || timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: owner's request forwarded, completion/timeout returned to owner.
  // Host-facing responses are suppressed while rst is held so a reset
  // mid-transaction never produces a ready pulse.
  always_comb begin
    grant          = 2'b00;
    dev_address    = '0;
    dev_data_write = '0;
    dev_write_mask = '0;
    dev_ren        = 1'b0;
    dev_wen        = 1'b0;
    h0_ready       = 1'b0;
    h0_data_read   = '0;
    h1_ready       = 1'b0;
    h1_data_read   = '0;
    bus_error      = 1'b0;
    case (state_q)
      G0: begin
        grant          = 2'b01;
        dev_address    = h0_address;
        dev_data_write = h0_data_write;
        dev_write_mask = h0_write_mask;
        dev_ren        = h0_ren & ~timeout;
        dev_wen        = h0_wen & ~timeout;
        h0_ready       = ~rst & (dev_ready | timeout);
        h0_data_read   = rst ? '0 : (timeout ? ERR_DATA : dev_data_read);
        bus_error      = ~rst & timeout;
      end
      G1: begin
        grant          = 2'b10;
        dev_address    = h1_address;
        dev_data_write = h1_data_write;
        dev_write_mask = h1_write_mask;
        dev_ren        = h1_ren & ~timeout;
        dev_wen        = h1_wen & ~timeout;
        h1_ready       = ~rst & (dev_ready | timeout);
        h1_data_read   = rst ? '0 : (timeout ? ERR_DATA : dev_data_read);
        bus_error      = ~rst & timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bus_host_arbiter_2.md
Name: bus_host_arbiter_2

Overview:
- Shares one downstream memory-mapped bus between two host ports, e.g. the pipelined core (host 0) and a DMA or debug loader (host 1).
- The downstream bus connects to the existing bus hub, so memory and parallel I/O are reachable from either host.
- Round-robin arbitration; one outstanding transaction at a time.
- A per-transaction watchdog terminates hung transactions with an error response.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in a grant state without dev_ready before forced termination; range 1..65535.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timed-out transaction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- h0_address  in  32  host 0 byte address
- h0_data_write  in  32  host 0 write data
- h0_write_mask  in  4  host 0 byte-lane write mask
- h0_ren  in  1  host 0 read request, held until h0_ready
- h0_wen  in  1  host 0 write request, held until h0_ready
- h0_data_read  out  32  host 0 read data, valid while h0_ready
- h0_ready  out  1  host 0 completion pulse
- h1_address, h1_data_write, h1_write_mask, h1_ren, h1_wen, h1_data_read, h1_ready: same as host 0, for host 1
- dev_address  out  32  downstream address
- dev_data_write  out  32  downstream write data
- dev_write_mask  out  4  downstream write mask
- dev_ren  out  1  downstream read request
- dev_wen  out  1  downstream write request
- dev_data_read  in  32  downstream read data
- dev_ready  in  1  downstream completion
- grant  out  2  one-hot current owner (bit0 = host 0, bit1 = host 1); 0 when idle
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- A host requests when it asserts ren or wen.
- States:
  - IDLE
  - G0: host 0 owns the bus
  - G1: host 1 owns the bus
- Reset: state=IDLE, last_grant=1 (host 0 wins the first tie), timeout counter=0.
- Outputs during reset: grant=0, all dev_* outputs 0, h*_ready=0, h*_data_read=0, bus_error=0.
- IDLE transitions, evaluated on the clock edge:
  - Only host 0 requesting → G0.
  - Only host 1 requesting → G1.
  - Both requesting → grant the host != last_grant.
  - On entering a grant state, last_grant takes that host index.
  - IDLE drives no downstream request; arbitration costs 1 cycle.
- In Gx:
  - dev_address, dev_data_write, dev_write_mask, dev_ren, dev_wen = host x inputs, combinationally.
  - The other host's requests are ignored and it sees ready=0 and data_read=0.
- Completion:
  - hx_ready = (state==Gx) & dev_ready, combinational.
  - hx_data_read = dev_data_read when state==Gx, else 0.
  - On the dev_ready edge: state → IDLE, counter → 0.
  - The guaranteed IDLE cycle lets the host drop its request before the downstream bus sees it again, which prevents duplicate accesses with registered-ready devices.
- Abandon: if in Gx host x drops both ren and wen without dev_ready → IDLE next cycle; no ready and no error.
- Timeout:
  - The counter (16 bits) increments each cycle in Gx without dev_ready.
  - When the counter == TIMEOUT_CYCLES-1 and dev_ready=0, that cycle drives hx_ready=1, hx_data_read=ERR_DATA, bus_error=1.
  - Next state IDLE; dev_* requests are forced to 0 in that cycle.
- Simultaneous dev_ready and timeout in the same cycle: dev_ready wins; normal completion, no error.
- rst asserted mid-transaction: return to IDLE next edge; no ready pulse to either host; the downstream request drops in the cycle after rst is sampled.
- Both ren and wen asserted by a host: forwarded unchanged; the arbiter does not resolve the conflict.
- Fairness: under continuous requests from both hosts, grants alternate 0,1,0,1; each transaction occupies its grant state plus 1 IDLE cycle.

Test Plan:
- Single read, host 0: h0_ren=1, addr=0x10; device replies dev_ready in the 2nd grant cycle with 0x12345678 → grant=01 at cycle 1; h0_ready pulse with h0_data_read=0x12345678 at cycle 2; IDLE at cycle 3; h1_ready stays 0.
- Simultaneous requests after reset: both hosts assert at once → host 0 served first, then host 1; with both held continuously, the grant sequence is 01,00,10,00,01.
- Write forwarding, host 1: addr 0x8000_0000, wdata 0xA5A5A5A5, mask 4'b0011 → dev_* outputs carry exactly those values while grant=10; h0_* inputs have no effect on dev_*.
- Timeout with TIMEOUT_CYCLES=4: device never readies → h0_ready, bus_error and h0_data_read=0xDEADBEEF asserted together in the 4th grant cycle, then IDLE.
- dev_ready in exactly the 4th grant cycle (TIMEOUT_CYCLES=4) → normal data returned, bus_error=0.
- Abandon and reset: host drops its request mid-grant → IDLE with no ready pulse. rst asserted mid-grant → IDLE, all outputs 0, and the next request is handled normally.
